// File: rtl/serial_full_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The master side requests an add; the slave side returns the result and the serial tap.
interface serial_full_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             sbit;
    logic             sbit_valid;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, sbit, sbit_valid
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, sbit, sbit_valid
    );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder, LSB first.
// Each RUN step builds one full-adder bit from two half-adder evaluations.
// The result is {cout, sum} = a + b + cin.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit pair consumed per enabled clock
// DONE  | done asserted; sum/cout valid; held while ena is low
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    serial_full_adder_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_r;
    logic             sbit_r;
    logic             sbit_valid_r;

    logic             ha_p;
    logic             fa_s;
    logic             fa_c;
    logic             last_step;

    // Two cascaded half-adder evaluations forming the full-adder bit.
    always_comb begin
        ha_p      = a_sr[0] ^ b_sr[0];
        fa_s      = ha_p ^ carry;
        fa_c      = (a_sr[0] & b_sr[0]) | (ha_p & carry);
        last_step = (cnt == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, carry FF, bit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr         <= '0;
            b_sr         <= '0;
            sum_r        <= '0;
            cnt          <= '0;
            carry        <= 1'b0;
            cout_r       <= 1'b0;
            sbit_r       <= 1'b0;
            sbit_valid_r <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_r        <= {fa_s, sum_r[WIDTH-1:1]};
                    carry        <= fa_c;
                    a_sr         <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr         <= {1'b0, b_sr[WIDTH-1:1]};
                    sbit_r       <= fa_s;
                    sbit_valid_r <= 1'b1;
                    cnt          <= cnt + CW'(1);
                    if (last_step) begin
                        cout_r <= fa_c;
                    end
                end
                DONE: begin
                    sbit_valid_r <= 1'b0;
                end
                default: begin
                    sbit_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs decoded from state; done stretches naturally while ena is low.
    always_comb begin
        bus.busy       = (state == RUN);
        bus.done       = (state == DONE);
        bus.sum        = sum_r;
        bus.cout       = cout_r;
        bus.sbit       = sbit_r;
        bus.sbit_valid = sbit_valid_r;
    end
endmodule

// File: tb/tb_serial_full_adder.sv
// Directed bench for the bit-serial adder: reset values, several sums,
// stray start, ena freeze and mid-operation reset.
module tb_serial_full_adder;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    logic ena;
    int   errors;
    int   checks;

    serial_full_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_full_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one add from IDLE. gap_at>0 drops ena for 5 edges after that step;
    // stray_at>0 pulses start with other operands during RUN.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                           input logic [7:0] exp_sum, input logic exp_cout,
                           input int gap_at, input int stray_at, input string tag);
        int          n;
        int          busy_n;
        int          nbits;
        int          extra_done;
        int          exp_lat;
        logic        got;
        logic        ena_prev;
        logic [15:0] seq;
        logic [7:0]  frz_sum;
        logic        frz_sbit;

        exp_lat = (gap_at > 0) ? WIDTH + 5 : WIDTH;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.cin   = tcin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'hA5;
        bus.b     = 8'h3B;
        bus.cin   = 1'b1;
        busy_n    = bus.busy ? 1 : 0;
        n         = 0;
        nbits     = 0;
        seq       = '0;
        got       = 1'b0;
        ena_prev  = 1'b1;
        frz_sum   = '0;
        frz_sbit  = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (!ena_prev) begin
                check({tag, "_freeze_sum"}, 32'(bus.sum), 32'(frz_sum));
                check({tag, "_freeze_sbit"}, 32'(bus.sbit), 32'(frz_sbit));
            end
            if (bus.busy) busy_n++;
            if (ena_prev && bus.sbit_valid) begin
                if (nbits < 16) seq[nbits] = bus.sbit;
                nbits++;
            end
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (n == gap_at) begin
                    frz_sum  = bus.sum;
                    frz_sbit = bus.sbit;
                end
                ena      = !(gap_at > 0 && n >= gap_at && n < gap_at + 5);
                ena_prev = ena;
                if (n == stray_at) begin
                    bus.start = 1'b1;
                    bus.a     = 8'h0F;
                    bus.b     = 8'hF0;
                    bus.cin   = 1'b1;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        ena       = 1'b1;
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        check({tag, "_nbits"}, 32'(nbits), 32'(WIDTH));
        check({tag, "_sbit_seq"}, 32'(seq[7:0]), 32'(exp_sum));
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check({tag, "_extra_done"}, 32'(extra_done), 32'd0);
        check({tag, "_sum_hold"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_cout_hold"}, 32'(bus.cout), 32'(exp_cout));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_sum"}, 32'(bus.sum), 32'd0);
        check({tag, "_cout"}, 32'(bus.cout), 32'd0);
        check({tag, "_sbit"}, 32'(bus.sbit), 32'd0);
        check({tag, "_sbit_valid"}, 32'(bus.sbit_valid), 32'd0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 0, "add_5a_3c");
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 0, "add_ff_01");
        run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 0, "add_ff_ff_c1");
        run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, "add_zero");
        run_add(8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 0, 3, "stray_start");
        run_add(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 3, 0, "ena_gap");

        // Reset in the middle of RUN must clear outputs without waiting for clk.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        check("midrst_held_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 0, "add_12_34");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
